// File: rtl/logic_gate_response_checker.sv
// Receive-side judge for the logic-gates-via-MUX bench: checks the seven gate outputs against
// the truth table for settled {a,b} samples. Define CHK_STOP_ON_FAIL_EN to end a run on the first mismatch.
module logic_gate_response_checker #(
   parameter int NUM_VECTORS   = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               a,
   input  logic                               b,
   input  logic                               yand,
   input  logic                               ynand,
   input  logic                               yor,
   input  logic                               ynor,
   input  logic                               ynot,
   input  logic                               yxor,
   input  logic                               yxnor,
   input  logic                               sample_valid,
   output logic                               busy,
   output logic                               done,
   output logic                               pass,
   output logic [ERR_CNT_W-1:0]               err_count,
   output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_count,
   output logic [3:0]                         coverage,
   output logic                               early_err,
   output logic [1:0]                         first_fail_vec,
   output logic [6:0]                         first_fail_mask,
   output logic [1:0]                         dbg_state
);
   localparam int VCW = $clog2(NUM_VECTORS + 1);
   localparam int SCW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_DONE = 2'd2} state_t;

   state_t               state_q, state_d;
   logic [1:0]           prev_ab_q, prev_ab_d;
   logic [SCW-1:0]       settle_q, settle_d;
   logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [ERR_CNT_W-1:0] err_q, err_d;
   logic [VCW-1:0]       vec_q, vec_d;
   logic [3:0]           cov_q, cov_d;
   logic                 early_q, early_d;
   logic [1:0]           ffv_q, ffv_d;
   logic [6:0]           ffm_q, ffm_d;

   logic [1:0] ab;
   logic       ab_chg, accept, run_end;
   logic [6:0] golden, observed, mask;

   // Handshake: sample_valid is a one-sided strobe; a sample counts only in ARMED with {a,b}
   // settled and unchanged this cycle, otherwise it is dropped (flagged as early_err in ARMED).
   always_comb begin
      ab       = {a, b};
      ab_chg   = (ab != prev_ab_q);
      golden   = {~(a ^ b), a ^ b, ~a, ~(a | b), a | b, ~(a & b), a & b};
      observed = {yxnor, yxor, ynot, ynor, yor, ynand, yand};
      mask     = observed ^ golden;
      accept   = (state_q == S_ARMED) && sample_valid && (settle_q == '0) && !ab_chg;
      run_end  = 1'b0;

      prev_ab_d = ab;
      if (ab_chg)               settle_d = SCW'(SETTLE_CYCLES);
      else if (settle_q != '0)  settle_d = settle_q - SCW'(1);
      else                      settle_d = settle_q;

      state_d = state_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      vec_d   = vec_q;
      cov_d   = cov_q;
      early_d = early_q;
      ffv_d   = ffv_q;
      ffm_d   = ffm_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_ARMED;
               pass_d  = 1'b0;
               err_d   = '0;
               vec_d   = '0;
               cov_d   = '0;
               early_d = 1'b0;
               ffv_d   = '0;
               ffm_d   = '0;
            end
         end
         S_ARMED: begin
            if (sample_valid && !accept) early_d = 1'b1;
            if (accept) begin
               vec_d     = vec_q + VCW'(1);
               cov_d[ab] = 1'b1;
               if (mask != '0) begin
                  if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
                  if (err_q == '0) begin
                     ffv_d = ab;
                     ffm_d = mask;
                  end
               end
`ifdef CHK_STOP_ON_FAIL_EN
               run_end = (vec_d == VCW'(NUM_VECTORS)) || (mask != '0);
`else
               run_end = (vec_d == VCW'(NUM_VECTORS));
`endif
               if (run_end) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  pass_d  = (err_d == '0) && (cov_d == 4'hF);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_ARMED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         prev_ab_q <= '0;
         settle_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         err_q     <= '0;
         vec_q     <= '0;
         cov_q     <= '0;
         early_q   <= 1'b0;
         ffv_q     <= '0;
         ffm_q     <= '0;
      end else begin
         state_q   <= state_d;
         prev_ab_q <= prev_ab_d;
         settle_q  <= settle_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         err_q     <= err_d;
         vec_q     <= vec_d;
         cov_q     <= cov_d;
         early_q   <= early_d;
         ffv_q     <= ffv_d;
         ffm_q     <= ffm_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_count       = err_q;
   assign vec_count       = vec_q;
   assign coverage        = cov_q;
   assign early_err       = early_q;
   assign first_fail_vec  = ffv_q;
   assign first_fail_mask = ffm_q;
   assign dbg_state       = state_q;
endmodule

// File: tb/tb_logic_gate_response_checker.sv
// Bench for logic_gate_response_checker: directed {a,b} sweeps with optional gate faults;
// expected run results are queued by the driver and checked on each done pulse.
module tb_logic_gate_response_checker;
   localparam int EW = 26;

   logic clk = 1'b0;
   logic rst, start, a, b, sample_valid;
   logic yand, ynand, yor, ynor, ynot, yxor, yxnor;
   logic busy, done, pass, early_err;
   logic [7:0] err_count;
   logic [2:0] vec_count;
   logic [3:0] coverage;
   logic [1:0] first_fail_vec, dbg_state;
   logic [6:0] first_fail_mask;

   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [6:0] fault_mask;
   logic [1:0] fault_ab;

   logic_gate_response_checker dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .yand(yand), .ynand(ynand), .yor(yor), .ynor(ynor), .ynot(ynot), .yxor(yxor), .yxnor(yxnor),
      .sample_valid(sample_valid), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .vec_count(vec_count), .coverage(coverage), .early_err(early_err),
      .first_fail_vec(first_fail_vec), .first_fail_mask(first_fail_mask), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic p, input logic [7:0] e, input logic [2:0] v,
                                        input logic [3:0] c, input logic ee, input logic [1:0] fv,
                                        input logic [6:0] fm);
      return {p, e, v, c, ee, fv, fm};
   endfunction

   // Gate-level stand-in for the DUT being judged, with an optional fault on one {a,b} combination.
   task automatic drive_ab(input logic [1:0] ab);
      logic [6:0] g;
      a = ab[1];
      b = ab[0];
      g = {~(ab[1] ^ ab[0]), ab[1] ^ ab[0], ~ab[1], ~(ab[1] | ab[0]), ab[1] | ab[0],
           ~(ab[1] & ab[0]), ab[1] & ab[0]};
      if (ab == fault_ab) g = g ^ fault_mask;
      {yxnor, yxor, ynot, ynor, yor, ynand, yand} = g;
   endtask

   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         logic [EW-1:0] e;
         done_cnt++;
         check("done_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pass", pass, e[25]);
            check("err_count", err_count, e[24:17]);
            check("vec_count", vec_count, e[16:14]);
            check("coverage", coverage, e[13:10]);
            check("early_err", early_err, e[9]);
            check("first_fail_vec", first_fail_vec, e[8:7]);
            check("first_fail_mask", first_fail_mask, e[6:0]);
         end
      end
   end

   task automatic sweep(input logic [7:0] vecs, input int nvec, input bit early, input bit push,
                        input logic [EW-1:0] exp);
      int d0;
      logic [1:0] ab;
      d0 = done_cnt;
      if (push) exp_q.push_back(exp);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("busy_after_start", busy, 1'b1);
      for (int vi = 0; vi < nvec; vi++) begin
         ab = vecs[7 - 2 * vi -: 2];
         for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (early && vi == 0 && k == 2) begin
               check("early_err_set", early_err, 1'b1);
               check("early_vec_unchanged", vec_count, 3'd0);
            end
            if (k == 0) drive_ab(ab);
            sample_valid = (k == 5) || (early && vi == 0 && k == 1);
         end
      end
      @(posedge clk); #1 sample_valid = 1'b0;
      if (push) begin
         for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
         #1;
         check("result_consumed", exp_q.size(), 0);
         check("done_pulses", done_cnt - d0, 1);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sample_valid = 1'b0;
      fault_mask = '0; fault_ab = '0;
      drive_ab(2'b00);
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_pass", pass, 1'b0);
      check("rst_err", err_count, 8'd0);
      check("rst_vec", vec_count, 3'd0);
      check("rst_cov", coverage, 4'd0);
      check("rst_early", early_err, 1'b0);
      check("rst_ffv", first_fail_vec, 2'd0);
      check("rst_ffm", first_fail_mask, 7'd0);
      check("rst_state", dbg_state, 2'd0);
      rst = 1'b0;

      // Clean sweep 00,01,10,11
      sweep(8'b00_01_10_11, 4, 1'b0, 1'b1, mk(1'b1, 8'd0, 3'd4, 4'hF, 1'b0, 2'b00, 7'h00));

      // yxor stuck at 0 on {a,b}=01
      fault_ab = 2'b01; fault_mask = 7'h20;
`ifdef CHK_STOP_ON_FAIL_EN
      sweep(8'b00_01_10_11, 4, 1'b0, 1'b1, mk(1'b0, 8'd1, 3'd2, 4'b0011, 1'b0, 2'b01, 7'h20));
`else
      sweep(8'b00_01_10_11, 4, 1'b0, 1'b1, mk(1'b0, 8'd1, 3'd4, 4'hF, 1'b0, 2'b01, 7'h20));
`endif
      fault_mask = '0;

      // sample_valid one cycle after {a,b} changes, then normal samples
      sweep(8'b00_01_10_11, 4, 1'b1, 1'b1, mk(1'b1, 8'd0, 3'd4, 4'hF, 1'b1, 2'b00, 7'h00));

      // Incomplete coverage
      sweep(8'b00_00_01_10, 4, 1'b0, 1'b1, mk(1'b0, 8'd0, 3'd4, 4'b0111, 1'b0, 2'b00, 7'h00));

      // Reset after two accepted samples, then a clean run
      sweep(8'b00_01_10_11, 2, 1'b0, 1'b0, '0);
      check("partial_vec", vec_count, 3'd2);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_vec", vec_count, 3'd0);
      check("abort_cov", coverage, 4'd0);
      sweep(8'b00_01_10_11, 4, 1'b0, 1'b1, mk(1'b1, 8'd0, 3'd4, 4'hF, 1'b0, 2'b00, 7'h00));

`ifdef CHK_STOP_ON_FAIL_EN
      fault_ab = 2'b00; fault_mask = 7'h10;
      sweep(8'b00_01_10_11, 4, 1'b0, 1'b1, mk(1'b0, 8'd1, 3'd1, 4'b0001, 1'b0, 2'b00, 7'h10));
      fault_mask = '0;
`endif

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
